// File: rtl/psk_pkg.sv
// Shared definitions for the streaming PSK modulator: mode constants,
// FSM state encoding and the saturating negation helper.
// Optional build macro: PSK_DIFF_ENC_EN (differential encoding in psk_mod_stream).
package psk_pkg;

  localparam logic MODE_QPSK = 1'b0;
  localparam logic MODE_BPSK = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } psk_state_e;

  // Two's-complement negation of a width-bit value carried in 32 bits.
  // The most negative value has no positive twin, so it clamps to the
  // largest positive value instead of wrapping back onto itself.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                 input int width);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (width - 1));
    if (x == most_neg) return -most_neg - 32'sd1;
    return -x;
  endfunction

endpackage

// File: rtl/psk_mod_stream_if.sv
// AXI-Stream style input bus of the PSK modulator.
// Handshake: a word moves on a clock edge where tvalid and tready are both
// high; tdata/tlast/tuser must be stable while tvalid is high, tvalid must
// not depend on tready, and tready may be asserted without tvalid.
interface psk_mod_stream_if #(
  parameter int BYTES = 1
);
  logic [BYTES*8-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic               tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/psk_symbol_mapper.sv
// Combinational symbol mapper: optionally swaps the I/Q carriers, then
// negates each rail (saturating) according to the symbol bit pair.
module psk_symbol_mapper
  import psk_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [1:0]              bits,
  input  logic signed [WIDTH-1:0] carrier_I,
  input  logic signed [WIDTH-1:0] carrier_Q,
  output logic signed [WIDTH-1:0] map_I,
  output logic signed [WIDTH-1:0] map_Q
);

  logic                    swap;
  logic signed [WIDTH-1:0] base_I;
  logic signed [WIDTH-1:0] base_Q;

  // Swap rails when the bits differ, then negate I by b0 and Q by b1.
  always_comb begin
    swap   = bits[1] ^ bits[0];
    base_I = swap ? carrier_Q : carrier_I;
    base_Q = swap ? carrier_I : carrier_Q;
    map_I  = bits[0] ? WIDTH'(sat_neg(32'(base_I), WIDTH)) : base_I;
    map_Q  = bits[1] ? WIDTH'(sat_neg(32'(base_Q), WIDTH)) : base_Q;
  end

endmodule

// File: rtl/psk_mod_stream.sv
// Streaming BPSK/QPSK modulator: accepts words over the stream bus,
// serialises them MSB first into symbols held for SPS enabled ticks each,
// and mixes every symbol with the incoming I/Q carrier.
// Optional build macro: PSK_DIFF_ENC_EN adds a 2-bit phase accumulator so
// symbols are differentially encoded.
module psk_mod_stream
  import psk_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int BYTES = 1,
  parameter int SPS   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_enable,
  psk_mod_stream_if.slave         s,
  input  logic signed [WIDTH-1:0] carrier_I,
  input  logic signed [WIDTH-1:0] carrier_Q,
  output logic signed [WIDTH-1:0] out_I,
  output logic signed [WIDTH-1:0] out_Q,
  output logic                    out_vld,
  output logic                    out_last,
  output logic                    out_is_bpsk,
  output logic [1:0]              out_bits,
  output logic                    out_sym_strobe,
  output logic                    underrun,
  output psk_state_e              state_dbg
);

  localparam int BITS  = BYTES * 8;
  localparam int CNT_W = $clog2(SPS);
  localparam int SYM_W = $clog2(BITS);

  psk_state_e              state_q, state_d;
  logic [BITS-1:0]         buf_q;
  logic                    mode_q;
  logic                    last_q;
  logic                    pkt_open_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [SYM_W-1:0]        sym_q;

  logic                    final_tick;
  logic                    final_sym;
  logic                    word_end;
  logic                    sym_start;
  logic                    ready_int;
  logic                    xfer;
  logic [1:0]              raw_bits;
  logic [1:0]              map_bits;
  logic signed [WIDTH-1:0] map_I;
  logic signed [WIDTH-1:0] map_Q;

  assign final_tick = (cnt_q == CNT_W'(SPS - 1));
  assign final_sym  = (mode_q == MODE_BPSK) ? (sym_q == SYM_W'(BITS - 1))
                                            : (sym_q == SYM_W'(BITS / 2 - 1));
  assign word_end   = (state_q == RUN) && final_tick && final_sym;
  assign sym_start  = (state_q == RUN) && (cnt_q == '0);
  assign ready_int  = clk_enable && ((state_q == IDLE) || word_end);
  assign s.tready   = ready_int;
  assign xfer       = s.tvalid && ready_int;
  assign raw_bits   = (mode_q == MODE_BPSK) ? {buf_q[BITS-1], buf_q[BITS-1]}
                                            : buf_q[BITS-1 -: 2];
  assign state_dbg  = state_q;

`ifdef PSK_DIFF_ENC_EN
  logic [1:0] p_q;
  logic [1:0] p_next;

  assign p_next   = (mode_q == MODE_BPSK) ? (p_q ^ {raw_bits[1], raw_bits[1]})
                                          : (p_q + raw_bits);
  // New phase takes effect on the symbol's first tick and is held after it.
  assign map_bits = sym_start ? p_next : p_q;

  // Phase accumulator: advance once per symbol, restart after a packet ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 2'b00;
    end else if (clk_enable) begin
      if (word_end && last_q) p_q <= 2'b00;
      else if (sym_start)     p_q <= p_next;
    end
  end
`else
  assign map_bits = raw_bits;
`endif

  psk_symbol_mapper #(.WIDTH(WIDTH)) u_mapper (
    .bits      (map_bits),
    .carrier_I (carrier_I),
    .carrier_Q (carrier_Q),
    .map_I     (map_I),
    .map_Q     (map_Q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a transfer always (re)starts RUN; a word end without one idles.
  always_comb begin
    state_d = state_q;
    if (clk_enable) begin
      if (xfer)          state_d = RUN;
      else if (word_end) state_d = IDLE;
    end
  end

  // Word buffer, per-word flags and symbol/tick counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      mode_q     <= MODE_QPSK;
      last_q     <= 1'b0;
      pkt_open_q <= 1'b0;
      cnt_q      <= '0;
      sym_q      <= '0;
    end else if (clk_enable) begin
      if (xfer) begin
        buf_q      <= s.tdata;
        mode_q     <= s.tuser;
        last_q     <= s.tlast;
        pkt_open_q <= !s.tlast;
        cnt_q      <= '0;
        sym_q      <= '0;
      end else if (state_q == RUN) begin
        cnt_q <= final_tick ? '0 : cnt_q + 1'b1;
        if (final_tick) begin
          sym_q <= sym_q + 1'b1;
          buf_q <= (mode_q == MODE_BPSK) ? {buf_q[BITS-2:0], 1'b0}
                                         : {buf_q[BITS-3:0], 2'b00};
        end
      end
    end
  end

  // Registered outputs: current symbol in RUN, silence (bits/mode held) in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_I          <= '0;
      out_Q          <= '0;
      out_vld        <= 1'b0;
      out_last       <= 1'b0;
      out_is_bpsk    <= 1'b0;
      out_bits       <= 2'b00;
      out_sym_strobe <= 1'b0;
      underrun       <= 1'b0;
    end else if (clk_enable) begin
      underrun <= word_end && !xfer && pkt_open_q;
      if (state_q == RUN) begin
        out_I          <= map_I;
        out_Q          <= map_Q;
        out_vld        <= 1'b1;
        out_last       <= last_q && final_sym;
        out_is_bpsk    <= mode_q;
        out_bits       <= map_bits;
        out_sym_strobe <= sym_start;
      end else begin
        out_I          <= '0;
        out_Q          <= '0;
        out_vld        <= 1'b0;
        out_last       <= 1'b0;
        out_sym_strobe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psk_mod_stream.sv
// Directed bench for psk_mod_stream (WIDTH=12, BYTES=1, SPS=4).
// Expected per-tick output records are hand-computed and queued; every tick
// pops one record (or an idle record when the queue is empty) and compares.
module tb_psk_mod_stream;
  import psk_pkg::*;

  localparam int WIDTH = 12;
  localparam int BYTES = 1;
  localparam int SPS   = 4;
  localparam int RW    = 31; // {underrun, vld, last, strobe, bpsk, bits[1:0], I[11:0], Q[11:0]}

  logic                    clk;
  logic                    rst_n;
  logic                    clk_enable;
  logic signed [WIDTH-1:0] carrier_I;
  logic signed [WIDTH-1:0] carrier_Q;
  logic signed [WIDTH-1:0] out_I;
  logic signed [WIDTH-1:0] out_Q;
  logic                    out_vld;
  logic                    out_last;
  logic                    out_is_bpsk;
  logic [1:0]              out_bits;
  logic                    out_sym_strobe;
  logic                    underrun;
  psk_state_e              state_dbg;

  psk_mod_stream_if #(.BYTES(BYTES)) s_if ();

  psk_mod_stream #(.WIDTH(WIDTH), .BYTES(BYTES), .SPS(SPS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_enable     (clk_enable),
    .s              (s_if.slave),
    .carrier_I      (carrier_I),
    .carrier_Q      (carrier_Q),
    .out_I          (out_I),
    .out_Q          (out_Q),
    .out_vld        (out_vld),
    .out_last       (out_last),
    .out_is_bpsk    (out_is_bpsk),
    .out_bits       (out_bits),
    .out_sym_strobe (out_sym_strobe),
    .underrun       (underrun),
    .state_dbg      (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_exp;
  logic [1:0]    hold_bits;
  logic          hold_bpsk;
  int            errors;
  int            checks;
  int            vld_cnt;
  int            strb_cnt;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] idle_rec();
    return {4'b0000, hold_bpsk, hold_bits, 24'd0};
  endfunction

  function automatic logic [RW-1:0] obs_rec();
    return {underrun, out_vld, out_last, out_sym_strobe, out_is_bpsk, out_bits,
            out_I, out_Q};
  endfunction

  // Queue one symbol: SPS records, strobe on the first, optional underrun on the last.
  task automatic push_sym(input int i, input int q, input logic [1:0] b,
                          input logic bpsk, input logic last, input logic ur);
    logic [RW-1:0] rec;
    for (int t = 0; t < SPS; t++) begin
      rec = {ur && (t == SPS - 1), 1'b1, last, t == 0, bpsk, b, i[11:0], q[11:0]};
      exp_q.push_back(rec);
    end
  endtask

  // One clock: advance, then compare outputs against the next expected record.
  task automatic tick();
    logic          en;
    logic [RW-1:0] exp_r;
    en = clk_enable;
    @(posedge clk);
    #1;
    if (en) begin
      if (exp_q.size() > 0) exp_r = exp_q.pop_front();
      else                  exp_r = idle_rec();
    end else begin
      exp_r = last_exp;
    end
    last_exp = exp_r;
    if (exp_r[29]) begin
      hold_bpsk = exp_r[26];
      hold_bits = exp_r[25:24];
    end
    if (out_vld) vld_cnt++;
    if (out_sym_strobe) strb_cnt++;
    check("tick", obs_rec(), exp_r);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Offer one word and wait (bounded) for the handshake edge.
  task automatic send_word(input logic [7:0] data, input logic last, input logic bpsk);
    logic hs;
    hs = 1'b0;
    s_if.tdata  = data;
    s_if.tlast  = last;
    s_if.tuser  = bpsk;
    s_if.tvalid = 1'b1;
    #1;
    for (int n = 0; n < 40; n++) begin
      hs = s_if.tready;
      tick();
      if (hs) break;
    end
    s_if.tvalid = 1'b0;
    check("xfer", RW'(hs), RW'(1'b1));
  endtask

  task automatic reset_scoreboard();
    exp_q.delete();
    hold_bits = 2'b00;
    hold_bpsk = 1'b0;
    last_exp  = '0;
  endtask

  logic [15:0] rdy_pat;
  logic [7:0]  w;

  initial begin
    errors      = 0;
    checks      = 0;
    vld_cnt     = 0;
    strb_cnt    = 0;
    rst_n       = 1'b0;
    clk_enable  = 1'b1;
    carrier_I   = 12'sd1000;
    carrier_Q   = -12'sd500;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    reset_scoreboard();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", obs_rec(), '0);
    check("reset_state", RW'(state_dbg), RW'(IDLE));
    rst_n = 1'b1;
    run(2);

`ifdef PSK_DIFF_ENC_EN
    // QPSK 0x55 differential: phase 01,10,11,00
    send_word(8'h55, 1'b1, 1'b0);
    push_sym(500, 1000, 2'b01, 1'b0, 1'b0, 1'b0);
    push_sym(-500, -1000, 2'b10, 1'b0, 1'b0, 1'b0);
    push_sym(-1000, 500, 2'b11, 1'b0, 1'b0, 1'b0);
    push_sym(1000, -500, 2'b00, 1'b0, 1'b1, 1'b0);
    run(18);

    // Same word, reset mid-word
    send_word(8'h55, 1'b1, 1'b0);
    push_sym(500, 1000, 2'b01, 1'b0, 1'b0, 1'b0);
    push_sym(-500, -1000, 2'b10, 1'b0, 1'b0, 1'b0);
    run(6);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out", obs_rec(), '0);
    check("midreset_state", RW'(state_dbg), RW'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    reset_scoreboard();
    run(3);

    // Phase restarted from 00
    send_word(8'h55, 1'b1, 1'b0);
    push_sym(500, 1000, 2'b01, 1'b0, 1'b0, 1'b0);
    push_sym(-500, -1000, 2'b10, 1'b0, 1'b0, 1'b0);
    push_sym(-1000, 500, 2'b11, 1'b0, 1'b0, 1'b0);
    push_sym(1000, -500, 2'b00, 1'b0, 1'b1, 1'b0);
    run(18);
`else
    // QPSK 0xB4 with tlast: 10 11 01 00
    send_word(8'hB4, 1'b1, 1'b0);
    push_sym(-500, -1000, 2'b10, 1'b0, 1'b0, 1'b0);
    push_sym(-1000, 500, 2'b11, 1'b0, 1'b0, 1'b0);
    push_sym(500, 1000, 2'b01, 1'b0, 1'b0, 1'b0);
    push_sym(1000, -500, 2'b00, 1'b0, 1'b1, 1'b0);
    run(18);

    // BPSK 0xA5 with tlast: 1,0,1,0,0,1,0,1
    send_word(8'hA5, 1'b1, 1'b1);
    w = 8'hA5;
    for (int k = 7; k >= 0; k--) begin
      if (w[k]) push_sym(-1000, 500, 2'b11, 1'b1, k == 0, 1'b0);
      else      push_sym(1000, -500, 2'b00, 1'b1, k == 0, 1'b0);
    end
    run(34);

    // Back-to-back QPSK: 0x1B (no tlast) then 0xE4 (tlast)
    send_word(8'h1B, 1'b0, 1'b0);
    vld_cnt  = 0;
    strb_cnt = 0;
    push_sym(1000, -500, 2'b00, 1'b0, 1'b0, 1'b0);
    push_sym(500, 1000, 2'b01, 1'b0, 1'b0, 1'b0);
    push_sym(-500, -1000, 2'b10, 1'b0, 1'b0, 1'b0);
    push_sym(-1000, 500, 2'b11, 1'b0, 1'b0, 1'b0);
    s_if.tdata  = 8'hE4;
    s_if.tlast  = 1'b1;
    s_if.tuser  = 1'b0;
    s_if.tvalid = 1'b1;
    rdy_pat     = '0;
    for (int i = 0; i < 16; i++) begin
      #1;
      rdy_pat[i] = s_if.tready;
      tick();
    end
    s_if.tvalid = 1'b0;
    push_sym(-1000, 500, 2'b11, 1'b0, 1'b0, 1'b0);
    push_sym(-500, -1000, 2'b10, 1'b0, 1'b0, 1'b0);
    push_sym(500, 1000, 2'b01, 1'b0, 1'b0, 1'b0);
    push_sym(1000, -500, 2'b00, 1'b0, 1'b1, 1'b0);
    run(17);
    check("b2b_ready", RW'(rdy_pat), RW'(16'h8000));
    check("b2b_vld_ticks", RW'(vld_cnt), RW'(32));
    check("b2b_strobes", RW'(strb_cnt), RW'(8));

    // Saturation: carrier_I = -2048, QPSK 11 -> out_I = 2047; clk_enable gap mid-word
    carrier_I = -12'sd2048;
    send_word(8'hFF, 1'b1, 1'b0);
    push_sym(2047, 500, 2'b11, 1'b0, 1'b0, 1'b0);
    push_sym(2047, 500, 2'b11, 1'b0, 1'b0, 1'b0);
    push_sym(2047, 500, 2'b11, 1'b0, 1'b0, 1'b0);
    push_sym(2047, 500, 2'b11, 1'b0, 1'b1, 1'b0);
    run(5);
    clk_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gap_ready", RW'(s_if.tready), RW'(1'b0));
      tick();
    end
    clk_enable = 1'b1;
    run(13);
    carrier_I = 12'sd1000;

    // Underrun: word without tlast, then source idle
    send_word(8'h00, 1'b0, 1'b0);
    push_sym(1000, -500, 2'b00, 1'b0, 1'b0, 1'b0);
    push_sym(1000, -500, 2'b00, 1'b0, 1'b0, 1'b0);
    push_sym(1000, -500, 2'b00, 1'b0, 1'b0, 1'b0);
    push_sym(1000, -500, 2'b00, 1'b0, 1'b0, 1'b1);
    run(20);

    // Reset mid-word discards the word at once
    send_word(8'hB4, 1'b1, 1'b0);
    push_sym(-500, -1000, 2'b10, 1'b0, 1'b0, 1'b0);
    push_sym(-1000, 500, 2'b11, 1'b0, 1'b0, 1'b0);
    run(6);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out", obs_rec(), '0);
    check("midreset_state", RW'(state_dbg), RW'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    reset_scoreboard();
    run(4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psk_mod_stream.md
# psk_mod_stream

Parametrised successor to the fixed-rate PSK modulator: accepts multi-byte AXI-Stream words, serialises them into BPSK (1 bit/symbol) or QPSK (2 bits/symbol) symbols, holds each symbol for a programmable number of enabled ticks, and mixes it with the I/Q carrier. It sits between the framing/packet source and the DAC/upconversion path. It provides:

- Full AXI back-pressure, with no fixed sampling slot.
- Per-word mode selection.
- Underrun reporting.
- Saturating negation.

## Interface
- WIDTH, 12, carrier and output sample width (signed)
- BYTES, 1, input word width in bytes; BITS = BYTES*8
- SPS, 8, enabled ticks per symbol, 2..256

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clk_enable  in  1  tick qualifier; all state advances only when high
- s_tdata  in  BITS  payload, MSB transmitted first
- s_tvalid  in  1  source valid
- s_tready  out  1  combinational: clk_enable & (buffer empty | final tick of final symbol of current word)
- s_tlast  in  1  last word of packet
- s_tuser  in  1  1 = BPSK, 0 = QPSK for this word
- carrier_I, carrier_Q  in  WIDTH signed  carrier samples
- out_I, out_Q  out  WIDTH signed  modulated samples
- out_vld  out  1  symbol active
- out_last  out  1  final symbol of a tlast word
- out_is_bpsk  out  1  mode of current symbol
- out_bits  out  2  mapped bit pair {b1,b0}
- out_sym_strobe  out  1  high on the first tick of each symbol
- underrun  out  1  one-tick pulse when a symbol boundary finds no word available while a packet is open (previous word had no tlast)

## Operation
- States:
  - IDLE: buffer empty.
  - RUN: symbols remaining in the current word.
- Transfer: s_tvalid & s_tready at a clk edge.
  - Loads the bit buffer, mode and last flag.
  - Clears the tick counter and the symbol index.
  - Enters RUN.
- Symbols per word:
  - BITS for BPSK.
  - BITS/2 for QPSK.
- Symbol bit extraction:
  - QPSK takes the two MSBs, b1 = first bit.
  - BPSK takes one MSB, and b0 = b1.
  - The buffer shifts left by 1 (BPSK) or 2 (QPSK) at each symbol boundary.
- Tick counter counts 0..SPS-1 on enabled ticks.
- At the final tick of the final symbol:
  - If a transfer occurs, the next word starts seamlessly (RUN).
  - Otherwise the block goes to IDLE.
- Mapping is done by the mapper sub-module:
  - Swap: base_I = b1^b0 ? carrier_Q : carrier_I; base_Q = b1^b0 ? carrier_I : carrier_Q.
  - out_I = b0 ? −base_I : base_I.
  - out_Q = b1 ? −base_Q : base_Q.
- Negation saturates: −(−2^(WIDTH−1)) yields 2^(WIDTH−1)−1.
- In IDLE, the outputs on every enabled tick are:
  - out_I = out_Q = 0.
  - out_vld = out_last = out_sym_strobe = 0.
  - out_bits and out_is_bpsk hold their last values.
- clk_enable low: all registers hold; s_tready = 0.

## Timing
- Reset values:
  - out_I = out_Q = 0; out_bits = 0.
  - out_vld = out_last = out_is_bpsk = out_sym_strobe = underrun = 0.
  - State IDLE, buffer cleared.
- Reset mid-word discards the partial word immediately; no further output.
- Latency: for a word transferred on enabled edge k, the first symbol appears on out_* after enabled edge k+1, with out_sym_strobe high for that tick.
- Each symbol is held for exactly SPS enabled ticks. Back-to-back words have no gap ticks.
- out_last is high for all SPS ticks of the final symbol of a tlast word.
- underrun:
  - Fires on the tick that would have started a new symbol.
  - The block is in IDLE on that tick.
  - The open-packet flag clears after tlast or reset.
- Mode and last flag are latched per word. A change of s_tuser mid-word has no effect.

## Configuration
- PSK_DIFF_ENC_EN defined: differential encoding.
  - Phase accumulator P (2 bits, reset 00) is updated per symbol:
    - QPSK: P ← P + {b1,b0} mod 4.
    - BPSK: P ← P ^ {b1,b1}.
  - P, not the raw bits, drives the mapper and out_bits.
  - P resets to 00 after the final symbol of a tlast word.
- Undefined: raw bits map directly; the accumulator is absent.

## Structure
- Package psk_pkg:
  - Mode constants MODE_QPSK = 0 and MODE_BPSK = 1.
  - State encoding IDLE/RUN.
  - Function sat_neg(WIDTH-bit).
- Sub-module psk_symbol_mapper: combinational swap/negate/saturate. Parameter WIDTH; inputs bits[1:0], carrier I/Q; outputs I/Q.

## Test plan
All scenarios use SPS=4, BYTES=1, carrier_I=1000, carrier_Q=−500 constant, unless stated.

- QPSK 0xB4, tlast=1: expect (I,Q) = (−500,−1000), (−1000,500), (500,1000), (1000,−500), each for 4 ticks. out_last is high only on the final 4 ticks.
- BPSK 0xA5: expect 8 symbols alternating (−1000,500)/(1000,−500) per bits 1,0,1,0,0,1,0,1.
- Two QPSK words held valid back-to-back: s_tready high exactly on the 16th tick. There are 32 contiguous valid ticks and 8 strobes.
- carrier_I = −2048, QPSK bits 11: out_I = 2047.
- Word without tlast, source then idle: underrun pulses once at tick 16; outputs become 0 and out_vld = 0.
- With PSK_DIFF_ENC_EN, QPSK 0x55: out_bits sequence 01, 10, 11, 00. Repeat with rst_n asserted mid-word: outputs become 0 at once and P = 00.
